// File: rtl/adc_scan_sequencer.sv
// Round-robin scan sequencer for the LTC2308 conversion engine: walks the enabled
// channels with a 4-phase req/done handshake and keeps the latest result per channel.
module adc_scan_sequencer #(
    parameter int unsigned SCAN_INTERVAL = 15000,
    parameter int unsigned TIMEOUT       = 2000
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        scan_en,
    input  logic [7:0]  ch_mask,
    input  logic        err_clr,
    output logic        adc_req,
    output logic [2:0]  adc_chan,
    input  logic        adc_done,
    input  logic [11:0] adc_result,
    output logic [95:0] ch_data,
    output logic [7:0]  ch_valid,
    output logic        data_strobe,
    output logic [2:0]  data_chan,
    output logic        frame_done,
    output logic        timeout_err,
    output logic        busy
);

    localparam int unsigned CNT_MAX = (TIMEOUT > SCAN_INTERVAL) ? TIMEOUT : SCAN_INTERVAL;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SI_LAST = CNT_W'(SCAN_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CONVERT,
        S_STORE,
        S_NEXT,
        S_WAIT
    } state_t;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // {found, index} of the lowest mask bit strictly above cur
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        next_above = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_above = {1'b1, 3'(i)};
        end
    endfunction

    state_t           state_q, state_d;
    logic             adc_req_q, adc_req_d;
    logic [2:0]       adc_chan_q, adc_chan_d;
    logic [7:0]       mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ch_valid_q, ch_valid_d;
    logic             data_strobe_q, data_strobe_d;
    logic [2:0]       data_chan_q, data_chan_d;
    logic             frame_done_q, frame_done_d;
    logic             timeout_err_q, timeout_err_d;
    logic             busy_q, busy_d;
    logic [11:0]      ch_data_q [8];
    logic             sync1_q, done_s_q, done_s_dly_q;
    logic             done_rise;
    logic             store_en;
    logic             timeout_set;
    logic [3:0]       nxt;

    assign done_rise = done_s_q & ~done_s_dly_q;
    assign nxt       = next_above(mask_q, adc_chan_q);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            done_s_q     <= 1'b0;
            done_s_dly_q <= 1'b0;
        end else begin
            sync1_q      <= adc_done;
            done_s_q     <= sync1_q;
            done_s_dly_q <= done_s_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        adc_req_d     = adc_req_q;
        adc_chan_d    = adc_chan_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        ch_valid_d    = ch_valid_q;
        data_strobe_d = 1'b0;
        data_chan_d   = data_chan_q;
        frame_done_d  = 1'b0;
        store_en      = 1'b0;
        timeout_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                adc_req_d = 1'b0;
                if (scan_en && (ch_mask != 8'd0)) begin
                    mask_d     = ch_mask;
                    adc_chan_d = lowest_bit(ch_mask);
                    state_d    = S_START;
                end
            end
            S_START: begin
                // previous handshake must have returned to zero first
                if (!done_s_q) begin
                    adc_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_rise) begin
                    state_d = S_STORE;
                end else if (cnt_q == TO_LAST) begin
                    adc_req_d   = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = S_NEXT;
                end
            end
            S_STORE: begin
                adc_req_d              = 1'b0;
                store_en               = 1'b1;
                ch_valid_d[adc_chan_q] = 1'b1;
                data_chan_d            = adc_chan_q;
                data_strobe_d          = 1'b1;
                state_d                = S_NEXT;
            end
            S_NEXT: begin
                if (!scan_en) begin
                    state_d = S_IDLE;
                end else if (nxt[3]) begin
                    adc_chan_d = nxt[2:0];
                    state_d    = S_START;
                end else begin
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                    if (SCAN_INTERVAL == 0) begin
                        if (ch_mask != 8'd0) begin
                            mask_d     = ch_mask;
                            adc_chan_d = lowest_bit(ch_mask);
                            state_d    = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SI_LAST) begin
                    if (scan_en && (ch_mask != 8'd0)) begin
                        mask_d     = ch_mask;
                        adc_chan_d = lowest_bit(ch_mask);
                        state_d    = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // a timeout in the same cycle as err_clr keeps the flag set
        timeout_err_d = timeout_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            adc_req_q     <= 1'b0;
            adc_chan_q    <= 3'd0;
            mask_q        <= 8'd0;
            cnt_q         <= '0;
            ch_valid_q    <= 8'd0;
            data_strobe_q <= 1'b0;
            data_chan_q   <= 3'd0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < 8; i++) ch_data_q[i] <= 12'd0;
        end else begin
            state_q       <= state_d;
            adc_req_q     <= adc_req_d;
            adc_chan_q    <= adc_chan_d;
            mask_q        <= mask_d;
            cnt_q         <= cnt_d;
            ch_valid_q    <= ch_valid_d;
            data_strobe_q <= data_strobe_d;
            data_chan_q   <= data_chan_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            if (store_en) ch_data_q[adc_chan_q] <= adc_result;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_ch_data
        assign ch_data[gi*12 +: 12] = ch_data_q[gi];
    end

    assign adc_req     = adc_req_q;
    assign adc_chan    = adc_chan_q;
    assign ch_valid    = ch_valid_q;
    assign data_strobe = data_strobe_q;
    assign data_chan   = data_chan_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Sequences the LTC2308 SPI conversion engine across up to eight analog channels using a programmable enable mask. It replaces the fixed two-channel toggle with a round-robin scheduler. It uses a 4-phase request/done handshake that crosses into the divided ADC clock domain. It holds the latest 12-bit result per channel for the servo, joystick and display logic, and flags conversions that never complete.

## Interface
- SCAN_INTERVAL, 15000: idle CLOCK_50 cycles between end of one frame and start of the next; 0 = back-to-back frames.
- TIMEOUT, 2000: CLOCK_50 cycles allowed in CONVERT before a conversion is abandoned; must be ≥ 2.
- CLOCK_50  in  1  system clock; all logic in this domain.
- reset_n  in  1  asynchronous, active-low reset.
- scan_en  in  1  level; enables scanning.
- ch_mask  in  8  channel enable, bit i = channel i; latched at frame start.
- err_clr  in  1  single-cycle pulse; clears timeout_err.
- adc_req  out  1  level conversion request to ADC engine.
- adc_chan  out  3  channel for the current conversion; stable while adc_req is high.
- adc_done  in  1  level from ADC clock domain; high while adc_result is valid; async, synchronized internally.
- adc_result  in  12  conversion result; stable while adc_done is high.
- ch_data  out  96  channel i result at bits [12i+11:12i].
- ch_valid  out  8  bit i sticky high once channel i has been stored.
- data_strobe  out  1  one-cycle pulse per stored result.
- data_chan  out  3  channel of the last stored result.
- frame_done  out  1  one-cycle pulse at the end of a completed frame.
- timeout_err  out  1  sticky; set on timeout.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset: state IDLE. All outputs are 0, including ch_data, ch_valid, adc_chan, data_chan and the synchronizer flops.
- adc_done passes through a 2-flop synchronizer (done_s). done_rise = done_s & ~done_s_d.
- States:
  - IDLE → START when scan_en=1 and ch_mask≠0. On this transition, latch ch_mask into mask_q and set adc_chan to the lowest set bit.
  - START: wait until done_s=0 (return-to-zero of the previous handshake). Then assert adc_req, clear the timeout counter, → CONVERT.
  - CONVERT: adc_req held high; counter increments each cycle.
    - On done_rise → STORE.
    - Otherwise, when counter = TIMEOUT-1: drop adc_req, set timeout_err, → NEXT with no store.
    - If done_rise and timeout coincide, done_rise wins.
  - STORE: drop adc_req. Write adc_result into ch_data[adc_chan], set ch_valid[adc_chan], load data_chan, pulse data_strobe. → NEXT.
  - NEXT:
    - If scan_en=0 → IDLE; no frame_done.
    - Else if mask_q has a set bit above adc_chan: set adc_chan to the next such bit, → START.
    - Else pulse frame_done. If SCAN_INTERVAL=0, relatch the mask and → START; otherwise → WAIT.
  - WAIT: counts SCAN_INTERVAL cycles, then:
    - If scan_en=1 and ch_mask≠0: relatch the mask, set adc_chan to the lowest set bit, → START.
    - Otherwise → IDLE.
- Channels within a frame are visited in ascending order; each channel is visited once per frame.
- scan_en falling mid-conversion does not abort. The current conversion completes or times out, then the block enters IDLE.
- ch_mask changes mid-frame are ignored until the next latch.
- err_clr clears timeout_err. If err_clr and a timeout occur in the same cycle, set wins.

## Timing
- adc_req rises one cycle after entering START, provided done_s=0.
- Response latency:
  - adc_done rising, sampled at edge N: done_s high after N+1, done_rise during cycle N+1→N+2.
  - STORE entered at N+2; ch_data, ch_valid and data_strobe visible after edge N+3; adc_req low after N+3.
- The minimum per-channel overhead beyond ADC conversion time is the synchronizer return-to-zero of 2 cycles plus START/STORE/NEXT.
- The WAIT count is exact: SCAN_INTERVAL cycles from the cycle after frame_done.
- Every strobe is exactly one cycle. All outputs are registered.

## Test plan
1. Mask 8'h03, SCAN_INTERVAL=0, ADC model returns 12'hA00 + chan after 40 cycles → repeating strobes chan 0,1; frame_done after each chan-1 strobe; ch_data[11:0]=12'hA00, [23:12]=12'hA01; ch_valid=8'h03.
2. Mask 8'b1010_0100 → order 2,5,7 then frame_done; adc_chan never takes an unmasked value; ch_valid=8'hA4.
3. ADC model never raises done on chan 3, TIMEOUT=2000 → adc_req drops exactly 2000 cycles after rise; timeout_err=1; no strobe for chan 3; scan proceeds to next channel. err_clr → 0.
4. scan_en dropped mid-CONVERT on chan 1 of mask 8'h07 → chan 1 stored, no frame_done, busy=0 afterwards, no further adc_req.
5. Assert reset_n low during CONVERT → all outputs 0 immediately. After release with mask 8'h01, the first adc_req appears only after done_s is 0.
6. SCAN_INTERVAL=100, mask 8'h01 → next adc_req rises 101 cycles after the frame_done pulse; a mask change to 8'h02 during WAIT is used in the next frame.
